bfis_result_collector: RTL and testbench

Host-side launcher and result sink for the best-first search engine. It accepts one query command: start vertex id, query vector and k. It holds the engine in reset, releases it, and captures the engine's streamed top-k vertex words into a local buffer. When the search finishes, it drains the buffered results to the host over a valid/ready stream.

---
 rtl/bfis_pkg.sv | 31 +++
 rtl/result_buffer.sv | 66 ++++++
 rtl/bfis_result_collector.sv | 232 +++++++++++++++++++++++
 tb/tb_bfis_result_collector.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfis_pkg.sv
// -----------------------------------------------------------------------------
// bfis_pkg
// Shared types and constants for the best-first-search result collector.
//   VERTEX_W / K_W / DIST_W : data widths shared with the search engine
//   QUERY_DIM               : default query vector dimension
//   query_vec_t             : QUERY_DIM x VERTEX_W packed query vector
//   collector_state_t       : collector FSM encoding
//   clamp_k()               : min(k, k_max) helper for the effective k
// -----------------------------------------------------------------------------
package bfis_pkg;

  localparam int VERTEX_W  = 32;
  localparam int K_W       = 16;
  localparam int DIST_W    = 32;
  localparam int QUERY_DIM = 2;

  typedef logic [QUERY_DIM-1:0][VERTEX_W-1:0] query_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } collector_state_t;

  function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k,
                                             input logic [K_W-1:0] k_max);
    return (k > k_max) ? k_max : k;
  endfunction

endpackage

// File: rtl/result_buffer.sv
// -----------------------------------------------------------------------------
// result_buffer
// DEPTH-deep register file filled in arrival order and read back in the same
// order. The write pointer is the fill count itself.
//   clk_in, rst_in   : clock, asynchronous active-low reset
//   clear_in         : empties the buffer (count and read pointer to 0)
//   wr_en_in/wr_data_in : append one word (ignored when full)
//   rd_en_in         : advance the read pointer (ignored when nothing left)
//   rd_data_out      : word at the read pointer
//   count_out        : number of words written since the last clear
//   rd_ptr_out       : number of words read since the last clear
// -----------------------------------------------------------------------------
module result_buffer
  import bfis_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = VERTEX_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear_in,
  input  logic                     wr_en_in,
  input  logic [W-1:0]             wr_data_in,
  input  logic                     rd_en_in,
  output logic [W-1:0]             rd_data_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic [$clog2(DEPTH):0]   rd_ptr_out
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_wr_ok = wr_en_in && (r_count < CNT_W'(DEPTH));
  assign w_rd_ok = rd_en_in && (r_rd_ptr < r_count);

  // Storage carries no reset: a word is only ever read after it was written.
  always_ff @(posedge clk_in) begin
    if (w_wr_ok && !clear_in) begin
      r_mem[r_count[IDX_W-1:0]] <= wr_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
    end else if (clear_in) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_count  <= r_count + CNT_W'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
    end
  end

  assign rd_data_out = r_mem[r_rd_ptr[IDX_W-1:0]];
  assign count_out   = r_count;
  assign rd_ptr_out  = r_rd_ptr;

endmodule

// File: rtl/bfis_result_collector.sv
// -----------------------------------------------------------------------------
// bfis_result_collector
// Host-side launcher and result sink for the best-first search engine.
// Accepts one query command, holds the engine in reset for ENGINE_RST_CYCLES,
// releases it, captures up to k_eff = min(k, K_MAX) streamed result words, then
// drains them to the host in arrival order.
//
// Optional build macro: BFIS_TIMEOUT_EN enables the collect-phase watchdog
// (TIMEOUT_CYCLES). Without it, COLLECT waits indefinitely and timeout_out=0.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   cmd_valid_in/cmd_ready_out  command handshake (ready only in IDLE)
//   cmd_vertex_id_in, cmd_query_in, cmd_k_in  command payload
//   engine_rst_out            active-high engine reset (low only in COLLECT)
//   engine_vertex_id_out, engine_query_out, engine_k_out  latched command
//   engine_top_k_in, engine_valid_in  engine result stream
//   res_data_out/res_valid_out/res_ready_in/res_last_out  host result stream
//   busy_out                  state != IDLE
//   done_out                  one-cycle query-complete pulse
//   count_out                 results captured for current/last query
//   timeout_out               sticky watchdog flag
//   state_dbg_out             current FSM state (collector_state_t encoding)
//
// Handshake semantics (both cmd and res streams): a transfer happens on a
// rising clk_in edge where valid and ready are both high. A source keeps valid
// and its payload unchanged until that transfer; ready may change freely.
// -----------------------------------------------------------------------------
module bfis_result_collector
  import bfis_pkg::*;
#(
  parameter int DIM               = QUERY_DIM,
  parameter int K_MAX             = 8,
  parameter int ENGINE_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 65536
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            cmd_valid_in,
  output logic                            cmd_ready_out,
  input  logic [VERTEX_W-1:0]             cmd_vertex_id_in,
  input  logic [DIM-1:0][VERTEX_W-1:0]    cmd_query_in,
  input  logic [K_W-1:0]                  cmd_k_in,
  output logic                            engine_rst_out,
  output logic [VERTEX_W-1:0]             engine_vertex_id_out,
  output logic [DIM-1:0][VERTEX_W-1:0]    engine_query_out,
  output logic [K_W-1:0]                  engine_k_out,
  input  logic [VERTEX_W-1:0]             engine_top_k_in,
  input  logic                            engine_valid_in,
  output logic [VERTEX_W-1:0]             res_data_out,
  output logic                            res_valid_out,
  input  logic                            res_ready_in,
  output logic                            res_last_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [$clog2(K_MAX):0]          count_out,
  output logic                            timeout_out,
  output logic [1:0]                      state_dbg_out
);

  localparam int CNT_W = $clog2(K_MAX) + 1;
  localparam int RST_W = (ENGINE_RST_CYCLES > 1) ? $clog2(ENGINE_RST_CYCLES) : 1;

  collector_state_t             r_state;
  logic [VERTEX_W-1:0]          r_vertex;
  logic [DIM-1:0][VERTEX_W-1:0] r_query;
  logic [K_W-1:0]               r_k_eff;
  logic [RST_W-1:0]             r_rst_cnt;
  logic                         r_done;
  logic                         r_res_valid;
  logic                         r_res_last;
  logic [VERTEX_W-1:0]          r_res_data;

  logic                         w_cmd_fire;
  logic [K_W-1:0]               w_k_eff;
  logic                         w_capture;
  logic                         w_full;
  logic [CNT_W-1:0]             w_count;
  logic [CNT_W-1:0]             w_count_next;
  logic [CNT_W-1:0]             w_rd_ptr;
  logic [VERTEX_W-1:0]          w_rd_data;
  logic                         w_out_fire;
  logic                         w_load;
  logic                         w_tmo_expire;

  assign w_cmd_fire = cmd_valid_in && (r_state == IDLE);
  assign w_k_eff    = clamp_k(cmd_k_in, K_W'(K_MAX));

  // Captures are gated by count < k_eff so words past k_eff can never land.
  assign w_capture    = (r_state == COLLECT) && engine_valid_in &&
                        (K_W'(w_count) < r_k_eff);
  assign w_full       = w_capture && ((K_W'(w_count) + K_W'(1)) == r_k_eff);
  assign w_count_next = w_count + CNT_W'(w_capture);

  // The output register reloads whenever it is empty or being consumed, which
  // gives one word per cycle under continuous res_ready_in.
  assign w_out_fire = r_res_valid && res_ready_in;
  assign w_load     = (r_state == DRAIN) && (!r_res_valid || res_ready_in) &&
                      (w_rd_ptr < w_count);

  result_buffer #(
    .DEPTH (K_MAX),
    .W     (VERTEX_W)
  ) u_buf (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (w_cmd_fire),
    .wr_en_in    (w_capture),
    .wr_data_in  (engine_top_k_in),
    .rd_en_in    (w_load),
    .rd_data_out (w_rd_data),
    .count_out   (w_count),
    .rd_ptr_out  (w_rd_ptr)
  );

`ifdef BFIS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  // Counter is zero on the first COLLECT cycle; expiry is the cycle in which
  // the TIMEOUT_CYCLES-th COLLECT cycle completes. A capture finishing k_eff
  // in that same cycle wins and counts as a normal completion.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tmo_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_tmo_cnt <= '0;
    end else if (r_state == COLLECT) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_expire = (r_state == COLLECT) && !w_full &&
                        ((r_tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES));
  assign timeout_out  = r_timeout;
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo_expire = 1'b0;
  assign timeout_out  = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_vertex    <= '0;
      r_query     <= '0;
      r_k_eff     <= '0;
      r_rst_cnt   <= '0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_data  <= '0;
`ifdef BFIS_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_vertex  <= cmd_vertex_id_in;
            r_query   <= cmd_query_in;
            r_k_eff   <= w_k_eff;
            r_rst_cnt <= RST_W'(ENGINE_RST_CYCLES - 1);
`ifdef BFIS_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (w_k_eff == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (r_rst_cnt == '0) begin
            r_state <= COLLECT;
          end else begin
            r_rst_cnt <= r_rst_cnt - RST_W'(1);
          end
        end
        COLLECT: begin
          if (w_full) begin
            r_state <= DRAIN;
          end else if (w_tmo_expire) begin
`ifdef BFIS_TIMEOUT_EN
            r_timeout <= 1'b1;
`endif
            if (w_count_next == '0) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_load) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_rd_data;
            r_res_last  <= ((w_rd_ptr + CNT_W'(1)) == w_count);
          end else if (w_out_fire) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
          end
          if (w_out_fire && r_res_last) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_out        = (r_state == IDLE);
  assign engine_rst_out       = (r_state != COLLECT);
  assign engine_vertex_id_out = r_vertex;
  assign engine_query_out     = r_query;
  assign engine_k_out         = r_k_eff;
  assign res_data_out         = r_res_data;
  assign res_valid_out        = r_res_valid;
  assign res_last_out         = r_res_last;
  assign busy_out             = (r_state != IDLE);
  assign done_out             = r_done;
  assign count_out            = w_count;
  assign state_dbg_out        = r_state;

endmodule

// File: tb/tb_bfis_result_collector.sv
// -----------------------------------------------------------------------------
// tb_bfis_result_collector
// Randomized bench for bfis_result_collector. Expected result words come from a
// query-level model: the stream of a query is the first min(k, K_MAX) words the
// engine emits (or fewer on a watchdog expiry), in emission order.
// -----------------------------------------------------------------------------
module tb_bfis_result_collector;
  import bfis_pkg::*;

  localparam int DIM   = 2;
  localparam int K_MAX = 8;
  localparam int ERC   = 2;
`ifdef BFIS_TIMEOUT_EN
  localparam int TMO   = 100;
`else
  localparam int TMO   = 65536;
`endif
  localparam int CNT_W = $clog2(K_MAX) + 1;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic                         cmd_valid_in;
  logic                         cmd_ready_out;
  logic [31:0]                  cmd_vertex_id_in;
  logic [DIM-1:0][31:0]         cmd_query_in;
  logic [15:0]                  cmd_k_in;
  logic                         engine_rst_out;
  logic [31:0]                  engine_vertex_id_out;
  logic [DIM-1:0][31:0]         engine_query_out;
  logic [15:0]                  engine_k_out;
  logic [31:0]                  engine_top_k_in;
  logic                         engine_valid_in;
  logic [31:0]                  res_data_out;
  logic                         res_valid_out;
  logic                         res_ready_in;
  logic                         res_last_out;
  logic                         busy_out;
  logic                         done_out;
  logic [CNT_W-1:0]             count_out;
  logic                         timeout_out;
  logic [1:0]                   state_dbg_out;

  bfis_result_collector #(
    .DIM               (DIM),
    .K_MAX             (K_MAX),
    .ENGINE_RST_CYCLES (ERC),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .cmd_valid_in         (cmd_valid_in),
    .cmd_ready_out        (cmd_ready_out),
    .cmd_vertex_id_in     (cmd_vertex_id_in),
    .cmd_query_in         (cmd_query_in),
    .cmd_k_in             (cmd_k_in),
    .engine_rst_out       (engine_rst_out),
    .engine_vertex_id_out (engine_vertex_id_out),
    .engine_query_out     (engine_query_out),
    .engine_k_out         (engine_k_out),
    .engine_top_k_in      (engine_top_k_in),
    .engine_valid_in      (engine_valid_in),
    .res_data_out         (res_data_out),
    .res_valid_out        (res_valid_out),
    .res_ready_in         (res_ready_in),
    .res_last_out         (res_last_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .count_out            (count_out),
    .timeout_out          (timeout_out),
    .state_dbg_out        (state_dbg_out)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0;
  int first_valid_cyc = 0;
  bit first_seen = 1'b0;
  int cap_cyc = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (rst_in && done_out) done_cnt++;
  end

  // Host sink: pattern 0 = always ready, 1 = 1,0,0 repeating, else random.
  initial begin
    res_ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0: res_ready_in = 1'b1;
        1: begin
          res_ready_in = (ready_phase == 0);
          ready_phase  = (ready_phase + 1) % 3;
        end
        default: res_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: order, last flag, and hold-while-stalled.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(res_valid_out), 32'd1);
        check_eq("hold_data", res_data_out, prev_data);
      end
      if (res_valid_out && !first_seen) begin
        first_seen      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (res_valid_out && res_ready_in) begin
        check_eq("stream_has_exp", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("stream_data", res_data_out, exp_q.pop_front());
          check_eq("stream_last", 32'(res_last_out), 32'(exp_q.size() == 0));
        end
      end
      prev_stall = res_valid_out && !res_ready_in;
      prev_data  = res_data_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] vid, input logic [DIM-1:0][31:0] q,
                          input int k);
    @(negedge clk_in);
    check_eq("cmd_ready_idle", 32'(cmd_ready_out), 32'd1);
    @(posedge clk_in);
    #1;
    cmd_valid_in     = 1'b1;
    cmd_vertex_id_in = vid;
    cmd_query_in     = q;
    cmd_k_in         = 16'(k);
    @(posedge clk_in);
    #1;
    cmd_valid_in     = 1'b0;
    cmd_k_in         = 16'($urandom);
  endtask

  // One full query: model, command, engine emission, completion checks.
  task automatic run_query(input int k, input int n, input int max_gap, input bit seq);
    int eff, n_exp, snap, lat, budget, gap;
    logic [31:0] vid;
    logic [DIM-1:0][31:0] q;
    logic [31:0] words[16];
    eff   = (k > K_MAX) ? K_MAX : k;
    n_exp = (n < eff) ? n : eff;
    for (int i = 0; i < 16; i++) words[i] = seq ? 32'((i + 1) * 16) : $urandom;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(words[i]);
    vid  = $urandom;
    q[0] = $urandom;
    q[1] = $urandom;
    snap = done_cnt;
    first_seen = 1'b0;
    send_cmd(vid, q, k);
    @(negedge clk_in);
    check_eq("eng_vertex", engine_vertex_id_out, vid);
    check_eq("eng_query0", engine_query_out[0], q[0]);
    check_eq("eng_query1", engine_query_out[1], q[1]);
    check_eq("eng_k", 32'(engine_k_out), 32'(eff));
    check_eq("timeout_cleared", 32'(timeout_out), 32'd0);
    if (eff == 0) begin
      check_eq("k0_done", 32'(done_out), 32'd1);
      check_eq("k0_busy", 32'(busy_out), 32'd0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_in);
        check_eq("k0_eng_rst", 32'(engine_rst_out), 32'd1);
        check_eq("k0_no_valid", 32'(res_valid_out), 32'd0);
      end
      check_eq("k0_done_once", 32'(done_cnt - snap), 32'd1);
      return;
    end
    check_eq("busy_cmd_ready", 32'(cmd_ready_out), 32'd0);
    check_eq("busy_flag", 32'(busy_out), 32'd1);
    lat = 1;
    while (engine_rst_out && lat < 50) begin
      @(negedge clk_in);
      lat++;
    end
    check_eq("launch_latency", 32'(lat), 32'(ERC + 1));
    for (int i = 0; i < n; i++) begin
      gap = seq ? 1 : $urandom_range(0, max_gap);
      repeat (gap) @(negedge clk_in);
      engine_valid_in = 1'b1;
      engine_top_k_in = words[i];
      if (i == eff - 1) cap_cyc = cyc;
      @(negedge clk_in);
      engine_valid_in = 1'b0;
      engine_top_k_in = $urandom;
    end
    budget = 0;
    while (done_cnt == snap && budget < 2000) begin
      @(negedge clk_in);
      budget++;
    end
    check_eq("done_seen", 32'(done_cnt != snap), 32'd1);
    repeat (3) @(negedge clk_in);
    check_eq("done_once", 32'(done_cnt - snap), 32'd1);
    check_eq("all_streamed", 32'(exp_q.size()), 32'd0);
    check_eq("count", 32'(count_out), 32'(n_exp));
    check_eq("idle_busy", 32'(busy_out), 32'd0);
    check_eq("idle_eng_rst", 32'(engine_rst_out), 32'd1);
    if (n >= eff) check_eq("cap_to_valid", 32'(first_valid_cyc - cap_cyc), 32'd2);
`ifdef BFIS_TIMEOUT_EN
    check_eq("timeout_flag", 32'(timeout_out), 32'(n < eff));
`else
    check_eq("timeout_flag", 32'(timeout_out), 32'd0);
`endif
    exp_q.delete();
  endtask

  // Reset during COLLECT after two captures; nothing may stream or complete.
  task automatic mid_reset_test();
    int snap, lat;
    logic [DIM-1:0][31:0] q;
    q    = '0;
    snap = done_cnt;
    send_cmd(32'h55, q, 5);
    lat = 0;
    while (engine_rst_out && lat < 50) begin
      @(negedge clk_in);
      lat++;
    end
    check_eq("mr_collect", 32'(engine_rst_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      engine_valid_in = 1'b1;
      engine_top_k_in = $urandom;
      @(negedge clk_in);
      engine_valid_in = 1'b0;
      @(negedge clk_in);
    end
    check_eq("mr_count2", 32'(count_out), 32'd2);
    #2 rst_in = 1'b0;
    #1;
    check_eq("mr_cmd_ready", 32'(cmd_ready_out), 32'd1);
    check_eq("mr_eng_rst", 32'(engine_rst_out), 32'd1);
    check_eq("mr_busy", 32'(busy_out), 32'd0);
    check_eq("mr_count", 32'(count_out), 32'd0);
    check_eq("mr_eng_k", 32'(engine_k_out), 32'd0);
    check_eq("mr_valid", 32'(res_valid_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_eq("mr_no_done", 32'(done_cnt - snap), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k, eff;
    rst_in           = 1'b0;
    cmd_valid_in     = 1'b0;
    cmd_vertex_id_in = '0;
    cmd_query_in     = '0;
    cmd_k_in         = '0;
    engine_top_k_in  = '0;
    engine_valid_in  = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_cmd_ready", 32'(cmd_ready_out), 32'd1);
    check_eq("rst_eng_rst", 32'(engine_rst_out), 32'd1);
    check_eq("rst_valid", 32'(res_valid_out), 32'd0);
    check_eq("rst_last", 32'(res_last_out), 32'd0);
    check_eq("rst_done", 32'(done_out), 32'd0);
    check_eq("rst_count", 32'(count_out), 32'd0);
    check_eq("rst_busy", 32'(busy_out), 32'd0);
    check_eq("rst_timeout", 32'(timeout_out), 32'd0);
    check_eq("rst_eng_k", 32'(engine_k_out), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;

    ready_mode = 0;
    run_query(3, 3, 1, 1'b1);      // basic: 0x10, 0x20, 0x30
    run_query(20, 12, 1, 1'b0);    // clamp to K_MAX
    ready_mode = 1;
    run_query(4, 4, 1, 1'b0);      // backpressure 1,0,0
    ready_mode = 0;
    run_query(0, 0, 0, 1'b0);      // k = 0
    mid_reset_test();
    run_query(3, 3, 2, 1'b0);      // fresh query after reset

    for (int t = 0; t < 10; t++) begin
      ready_mode = $urandom_range(0, 2);
      k   = $urandom_range(0, 12);
      eff = (k > K_MAX) ? K_MAX : k;
      run_query(k, eff + $urandom_range(0, 3), 3, 1'b0);
    end

`ifdef BFIS_TIMEOUT_EN
    ready_mode = 0;
    run_query(5, 2, 1, 1'b0);      // partial result on expiry
    run_query(4, 0, 0, 1'b0);      // expiry with nothing captured
    run_query(2, 2, 0, 1'b0);      // flag clears on next command
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
